ps2_line_buf: RTL and testbench
===============================

Name: ps2_line_buf

Overview:
Line-assembly stage directly downstream of ps2_key. It consumes the ASCII strobe (done/ascii) and collects characters into a line buffer, applying backspace editing. On Enter it drains the completed line, terminator included, as a valid/ready byte stream to the console/UART consumer. Keystrokes that cannot be held are dropped and flagged.

Parameters:
DEPTH, 32, maximum stored characters per line, excluding the terminator
AW, 5, index width; DEPTH = 2**AW
CH_CR, 8'h0D, line terminator code
CH_BS, 8'h08, backspace code

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  one-cycle strobe from ps2_key done
in_data  in  8  ASCII code from ps2_key; sampled only when in_valid=1
out_valid  out  1  stream byte available
out_ready  in  1  consumer accepts byte when out_valid && out_ready
out_data  out  8  stream byte
out_last  out  1  marks the terminator byte, which ends the line
busy  out  1  1 while in DRAIN state
len  out  AW+1  number of characters currently held (0..DEPTH)
ovf  out  1  sticky flag: a keystroke was dropped
ovf_clr  in  1  synchronous clear for ovf

Behaviour:
- Reset is asynchronous, active-low. While rst=0: state=FILL, len=0, rd=0, out_valid=0, out_last=0, out_data=0, busy=0, ovf=0. Buffer contents are don't-care.
- Two-state FSM: FILL and DRAIN. busy=(state==DRAIN).
- FILL: out_valid=0. Each in_valid cycle is processed once:
  - in_data==8'h00: ignored (break/non-ASCII keys).
  - CH_BS: if len>0, len<=len-1; if len==0, no effect. ovf is not set.
  - CH_CR: state<=DRAIN, rd<=0. len is unchanged. The CR itself is not stored.
  - any other code: if len<DEPTH, mem[len]<=in_data and len<=len+1. Otherwise the byte is dropped and ovf<=1.
- DRAIN: out_valid=1.
  - If rd<len: out_data=mem[rd], out_last=0.
  - If rd==len: out_data=CH_CR, out_last=1.
  - On a handshake with out_last=0: rd<=rd+1.
  - On a handshake with out_last=1: state<=FILL, len<=0, rd<=0. out_valid falls the next cycle.
  - Without out_ready, out_valid, out_data and out_last hold stable; no byte is ever retracted.
  - in_valid during DRAIN: byte dropped, ovf<=1. This includes CR and BS.
- Latency: CR strobe at cycle N gives out_valid=1 with the first byte at cycle N+1. With out_ready held at 1, a line of L characters drains in L+1 consecutive cycles.
- Empty line (CR with len==0): DRAIN emits only CH_CR with out_last=1.
- Full line (len==DEPTH): BS and CR are still honoured; only printable bytes drop.
- ovf_clr: clears ovf on the next edge. If a set event occurs in the same cycle, set wins and ovf stays 1.
- len is visible every cycle. During DRAIN it holds the line length until the final handshake.
- out_data/out_last may be driven combinationally from mem[rd]/rd. They must not glitch relative to clk-sampled consumers, i.e. they are derived only from registered state.
- Reset asserted mid-DRAIN aborts the line. After release the block is in FILL, empty, with out_valid=0.

Test Plan:
- Reset check: drive rst=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, len=0 and busy=0.
- Basic line: strobes 'h','i',CR (8'h68,8'h69,8'h0D) with out_ready=1 -> stream 68,69,0D on consecutive cycles starting the cycle after CR. out_last only on 0D, busy drops afterwards, ovf=0.
- Edit: 'a','b',BS,'c',CR plus one extra BS on an empty line first -> stream 61,63,0D. len sequence 0,1,2,1,2, then 0 after drain.
- Backpressure: line "xyz" with out_ready toggling 1,0,0,1,0,1,1 -> each byte held stable while stalled. Output is exactly 78,79,7A,0D with no duplicates.
- Overflow: 33 printable bytes 8'h41 then CR (DEPTH=32) -> len saturates at 32 and ovf=1. Drain yields 32×41 then 0D. Then ovf_clr pulse -> ovf=0. Repeat with ovf_clr coincident with a dropped byte -> ovf stays 1.
- Drop during drain / empty line: CR alone -> single 0D with out_last. Then a strobe 'q' while out_ready=0 in DRAIN -> dropped, ovf=1, and the next line starts empty.

Source files
------------

// File: rtl/ps2_line_buf_if.sv
// Keystroke input strobe and line output byte stream of the line buffer.
// Latency: none, wires only.
// Backpressure: out_ready stalls the out_* stream; the in_* strobe cannot be stalled.
interface ps2_line_buf_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    // Keyboard/consumer side: drives keystrokes and the ready signal.
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    // Line buffer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/ps2_line_buf.sv
// Collects ASCII keystrokes into a line with backspace editing, then streams the line plus CR.
// Latency: the first output byte is valid the cycle after the CR strobe; one byte per accepted handshake.
// Backpressure: out_* hold stable until out_ready; keystrokes that cannot be held are dropped and set ovf.
module ps2_line_buf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter logic [7:0]  CH_CR = 8'h0D,
    parameter logic [7:0]  CH_BS = 8'h08
) (
    input  logic          clk,
    input  logic          rst,
    ps2_line_buf_if.slave bus,
    output logic          busy,
    output logic [AW:0]   len,
    output logic          ovf,
    input  logic          ovf_clr
);
    localparam logic [0:0]  ST_FILL  = 1'b0;
    localparam logic [0:0]  ST_DRAIN = 1'b1;
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

    logic [0:0]  state;
    logic [AW:0] rd;
    logic [7:0]  mem [DEPTH];

    logic is_fill;
    logic is_drain;
    logic key_print;
    logic wr_en;
    logic drop;
    logic at_end;
    logic hs;

    // Decode the incoming keystroke and the drain position.
    always_comb begin
        is_fill   = (state == ST_FILL);
        is_drain  = (state == ST_DRAIN);
        key_print = (bus.in_data != 8'h00) && (bus.in_data != CH_BS) && (bus.in_data != CH_CR);
        wr_en     = is_fill && bus.in_valid && key_print && (len < FULL);
        // Anything arriving mid-drain is lost, as is a printable key on a full line.
        drop      = bus.in_valid && (is_drain || (key_print && (len == FULL)));
        at_end    = (rd == len);
        hs        = is_drain && bus.out_ready;
    end

    // Character storage; contents are only meaningful below len, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len[AW-1:0]] <= bus.in_data;
        end
    end

    // Line state machine: edit the line in FILL, walk the read pointer in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FILL;
            len   <= '0;
            rd    <= '0;
        end else if (is_fill) begin
            if (bus.in_valid) begin
                if (bus.in_data == CH_BS) begin
                    if (len != '0) begin
                        len <= len - 1'b1;
                    end
                end else if (bus.in_data == CH_CR) begin
                    state <= ST_DRAIN;
                    rd    <= '0;
                end else if (wr_en) begin
                    len <= len + 1'b1;
                end
            end
        end else if (hs) begin
            if (at_end) begin
                state <= ST_FILL;
                len   <= '0;
                rd    <= '0;
            end else begin
                rd <= rd + 1'b1;
            end
        end
    end

    // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Output stream comes straight from registered state, so it cannot glitch within a cycle.
    always_comb begin
        busy          = is_drain;
        bus.out_valid = is_drain;
        bus.out_last  = is_drain && at_end;
        bus.out_data  = 8'h00;
        if (is_drain) begin
            bus.out_data = at_end ? CH_CR : mem[rd[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_ps2_line_buf.sv
// Bench for ps2_line_buf: directed line scenarios plus random keystrokes against a queue model.
// Latency: model and DUT are compared every falling edge while out of reset.
// Backpressure: out_ready is scripted in directed tests and randomised in the random phase.
module tb_ps2_line_buf;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [5:0] len;
    logic       ovf;
    logic       ovf_clr;

    ps2_line_buf_if bus ();

    ps2_line_buf #(.DEPTH(32), .AW(5), .CH_CR(8'h0D), .CH_BS(8'h08)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .busy    (busy),
        .len     (len),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 0;
    bit rand_rdy = 0;

    // Reference model: the edited line, and the byte queue still to be sent.
    logic [7:0] line [$];
    logic [7:0] outq [$];
    bit         m_drain = 0;
    bit         m_ovf   = 0;
    bit         m_set;
    logic [7:0] got  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            cyc();
            k++;
        end
        check("drain_timeout_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp [$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check({name, "_byte"}, got[i], exp[i]);
    endtask

    function automatic logic [7:0] pick(input int cr_w);
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return 8'h00;
        if (r < 25) return BS;
        if (r < 25 + cr_w) return CR;
        return 8'($urandom_range(32, 126));
    endfunction

    // Model update at each rising edge (or async reset), from the rules of the line editor.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                line.delete();
                outq.delete();
                m_drain = 0;
                m_ovf   = 0;
            end else begin
                m_set = 0;
                if (!m_drain) begin
                    if (bus.in_valid && bus.in_data != 8'h00) begin
                        if (bus.in_data == BS) begin
                            if (line.size() > 0) void'(line.pop_back());
                        end else if (bus.in_data == CR) begin
                            outq = line;
                            outq.push_back(CR);
                            m_drain = 1;
                        end else if (line.size() < 32) begin
                            line.push_back(bus.in_data);
                        end else begin
                            m_set = 1;
                        end
                    end
                end else begin
                    if (bus.in_valid) m_set = 1;
                    if (bus.out_ready) begin
                        void'(outq.pop_front());
                        if (outq.size() == 0) begin
                            m_drain = 0;
                            line.delete();
                        end
                    end
                end
                if (m_set) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && !done) begin
                check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_drain});
                check("busy", {31'd0, busy}, {31'd0, m_drain});
                check("len", {26'd0, len}, line.size());
                check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
                if (m_drain) begin
                    check("out_data", {24'd0, bus.out_data}, {24'd0, outq[0]});
                    check("out_last", {31'd0, bus.out_last}, {31'd0, outq.size() == 1});
                end else begin
                    check("out_last_idle", {31'd0, bus.out_last}, 32'd0);
                end
                if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            end
        end
    end

    // Random ready generation for the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [7:0] exp [$];
        logic       pat [7];

        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.out_ready = 1'b1;
        ovf_clr = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_len", {26'd0, len}, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_len", {26'd0, len}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Basic line: "hi" then CR, ready held high.
        got.delete();
        strobe(8'h68);
        strobe(8'h69);
        strobe(CR);
        check("basic_first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("basic_first_data", {24'd0, bus.out_data}, 32'h68);
        cyc();
        check("basic_second_data", {24'd0, bus.out_data}, 32'h69);
        check("basic_second_last", {31'd0, bus.out_last}, 32'd0);
        cyc();
        check("basic_cr_data", {24'd0, bus.out_data}, 32'h0D);
        check("basic_cr_last", {31'd0, bus.out_last}, 32'd1);
        cyc();
        check("basic_busy_drop", {31'd0, busy}, 32'd0);
        check("basic_ovf", {31'd0, ovf}, 32'd0);
        exp = '{8'h68, 8'h69, 8'h0D};
        check_got("basic", exp);

        // Edit: BS on empty line, then a,b,BS,c,CR.
        got.delete();
        strobe(BS); check("edit_len0", {26'd0, len}, 32'd0);
        strobe(8'h61); check("edit_len1", {26'd0, len}, 32'd1);
        strobe(8'h62); check("edit_len2", {26'd0, len}, 32'd2);
        strobe(BS); check("edit_len3", {26'd0, len}, 32'd1);
        strobe(8'h63); check("edit_len4", {26'd0, len}, 32'd2);
        strobe(CR);
        wait_idle();
        check("edit_len_after", {26'd0, len}, 32'd0);
        exp = '{8'h61, 8'h63, 8'h0D};
        check_got("edit", exp);

        // Backpressure: "xyz" with a scripted ready pattern.
        got.delete();
        bus.out_ready = 1'b0;
        strobe(8'h78); strobe(8'h79); strobe(8'h7A); strobe(CR);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i];
            cyc();
        end
        bus.out_ready = 1'b1;
        check("bp_busy_done", {31'd0, busy}, 32'd0);
        exp = '{8'h78, 8'h79, 8'h7A, 8'h0D};
        check_got("bp", exp);

        // Overflow: 33 printable bytes on a 32-deep line.
        got.delete();
        for (int i = 0; i < 33; i++) strobe(8'h41);
        check("ovf_len_sat", {26'd0, len}, 32'd32);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        strobe(CR);
        wait_idle();
        exp.delete();
        for (int i = 0; i < 32; i++) exp.push_back(8'h41);
        exp.push_back(8'h0D);
        check_got("ovf_line", exp);
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 32; i++) strobe(8'h41);
        check("ovf2_pre", {31'd0, ovf}, 32'd0);
        ovf_clr = 1'b1;
        strobe(8'h41);
        ovf_clr = 1'b0;
        check("ovf_set_wins", {31'd0, ovf}, 32'd1);
        check("ovf2_len", {26'd0, len}, 32'd32);
        strobe(CR);
        wait_idle();
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;

        // Empty line and a drop while draining.
        got.delete();
        bus.out_ready = 1'b0;
        strobe(CR);
        check("empty_data", {24'd0, bus.out_data}, 32'h0D);
        check("empty_last", {31'd0, bus.out_last}, 32'd1);
        strobe(8'h71);
        check("drain_drop_ovf", {31'd0, ovf}, 32'd1);
        check("drain_drop_busy", {31'd0, busy}, 32'd1);
        bus.out_ready = 1'b1;
        wait_idle();
        check("drain_drop_len", {26'd0, len}, 32'd0);
        exp = '{8'h0D};
        check_got("empty", exp);
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;

        // Asynchronous reset in the middle of a drain.
        bus.out_ready = 1'b0;
        strobe(8'h61); strobe(8'h62); strobe(CR);
        #1 rst = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("arst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_len", {26'd0, len}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        check("arst_release_valid", {31'd0, bus.out_valid}, 32'd0);

        // Random keystrokes, ready and clears; second half makes CR rare to reach full lines.
        rand_rdy = 1;
        for (int i = 0; i < 6000; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = pick(i < 3000 ? 8 : 1);
            ovf_clr      = ($urandom_range(0, 15) == 0);
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        ovf_clr = 1'b0;
        wait_idle();
        cyc();

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
